lock_clear_ctrl: RTL and testbench
==================================

// Module: lock_clear_ctrl
// PURPOSE
//  Downstream consumer of the bottom-touch check. On each gravity tick it either
//  steps the falling piece down one row or, when bottom_touch is set, locks the
//  3x3 piece into the 10x10 playfield. It then scans for and clears full rows,
//  shifting the stack down, and requests a new piece. It owns the playfield
//  register that the touch check and the VGA renderer read.
// PARAMETERS
//  W   10  playfield width in cells; row y occupies field bits y*W .. y*W+W-1
//  H   10  playfield height in cells; row 0 is the top row
//  BS  3   piece bounding-box side; block bit index is r*BS+c
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  drop_tick     in   1      gravity pulse; sampled only in IDLE
//  bottom_touch  in   1      from the touch checker, valid with drop_tick
//  block         in   [0:8]  current piece shape
//  block_x       in   4      piece column origin
//  block_y       in   4      piece row origin
//  field         out  [0:99] playfield occupancy register, 1 = filled
//  fall_step     out  1      1-cycle pulse: move the piece down one row
//  spawn_req     out  1      1-cycle pulse: load a new piece
//  busy          out  1      high in LOCK, SCAN, SHIFT and SPAWN
//  lines         out  3      rows cleared by the most recent lock
//  game_over     out  1      sticky until reset
//  score         out  8      total rows cleared, saturating (SCORE_EN only)
// BEHAVIOUR
//  Reset values: field=0, fall_step=0, spawn_req=0, busy=0, lines=0,
//   game_over=0, score=0. State resets to IDLE with row_idx=H-1.
//  A reset asserted mid-lock or mid-clear aborts at once. No partial merge is kept.
//  States:
//   IDLE : drop_tick & !bottom_touch -> fall_step=1 next cycle, stay in IDLE.
//          drop_tick & bottom_touch -> LOCK. drop_tick is ignored in every
//          other state; there is no queueing.
//   LOCK : field |= piece cells. Cell (r,c) with block[r*BS+c]=1 maps to bit
//          (block_y+r)*W + block_x+c. A cell with row >= H or col >= W is
//          dropped silently, with no wrap. Set lines=0, row_idx=H-1, go to SCAN.
//   SCAN : if row row_idx is all ones -> SHIFT.
//          Else if row_idx==0 -> SPAWN. Else row_idx-1, stay in SCAN.
//   SHIFT: for rows k = row_idx down to 1, row k = row k-1; row 0 = 0.
//          lines+1. Return to SCAN with the SAME row_idx, because the new
//          content in that row must be rechecked.
//   SPAWN: spawn_req=1 for this one cycle. If row 0 or row 1 is nonzero ->
//          OVER, else -> IDLE.
//   OVER : game_over=1; field is frozen; all inputs are ignored until reset.
//  Latency, with the tick sampled at edge 0:
//   LOCK occupies cycle 1 and SCAN occupies cycles 2..11.
//   With no full rows, spawn_req is high in cycle 12.
//   Each cleared row adds one SHIFT cycle, for example 1 row -> cycle 13.
//  Piece inputs are sampled in LOCK only. Upstream must hold them stable
//   from the tick through LOCK.
//  lines is 3 bits wide. BS=3 bounds it to at most 3 per lock.
// CONFIGURATION
//  LOCK_SCORE_EN defined:
//   - in SPAWN, score <= min(255, score + lines).
//  LOCK_SCORE_EN undefined:
//   - score is tied to 8'd0 and no adder or register is built.
//  All other behaviour is identical in both builds.
// TESTING
//  1 Reset, then drop_tick with bottom_touch=0 -> fall_step pulses exactly 1 cycle,
//    field stays 0, busy stays 0.
//  2 Empty field; block=9'b111_000_000, x=2, y=9; tick with touch=1 ->
//    field bits 92..94 set, lines=0, spawn_req high in cycle 12, back in IDLE.
//  3 Row 9 = cells 0..6 filled plus row 8 bit 85 set; lock an I-piece
//    (block=111_000_000) at x=7, y=9 -> row 9 clears, old bit 85 now at 95,
//    lines=1, spawn_req in cycle 13.
//  4 Rows 8 and 9 each missing only col 9; lock block=001_001_000 at x=7, y=8
//    -> both rows clear, two SHIFT cycles, lines=2, field=0.
//  5 Row 1 is nonzero after the lock, with no clear -> spawn_req pulses once,
//    then game_over=1. Later drop_ticks change nothing. A reset clears everything.
//  6 Assert reset during SHIFT -> all outputs at reset values on the next edge.
//    With LOCK_SCORE_EN, preload score=254, clear 2 rows -> score=255 (saturated).

Source files
------------

// File: rtl/lock_clear_ctrl.sv
// lock_clear_ctrl: on a gravity tick, either steps the falling piece down or
// locks it into the playfield. After a lock it clears every full row, shifts
// the stack down, and requests the next piece. Owns the playfield register.
// Optional build macro: LOCK_SCORE_EN adds a saturating count of cleared rows.
module lock_clear_ctrl #(
    parameter int W  = 10,
    parameter int H  = 10,
    parameter int BS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drop_tick,
    input  logic             bottom_touch,
    input  logic [0:BS*BS-1] block,
    input  logic [3:0]       block_x,
    input  logic [3:0]       block_y,
    output logic [0:W*H-1]   field,
    output logic             fall_step,
    output logic             spawn_req,
    output logic             busy,
    output logic [2:0]       lines,
    output logic             game_over,
    output logic [7:0]       score
);

    localparam int FW = W * H;
    localparam int IW = $clog2(FW);
    localparam int RW = $clog2(H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_SCAN,
        S_SHIFT,
        S_SPAWN,
        S_OVER
    } state_t;

    state_t        state_q;
    logic [0:FW-1] field_q;
    logic [RW-1:0] row_idx_q;
    logic          fall_step_q;
    logic          spawn_q;
    logic          busy_q;
    logic [2:0]    lines_q;
    logic          over_q;

    logic [0:FW-1] field_lock_d;
    logic [0:FW-1] field_shift_d;
    logic [0:H-1]  row_full_vec;
    logic          row_full;
    logic          refill_full;
    logic          top_rows_busy;

    // Merge the piece into the field; cells past the right or bottom edge are dropped.
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        field_lock_d = field_q;
        for (int r = 0; r < BS; r++) begin
            for (int c = 0; c < BS; c++) begin
                if (block[r*BS + c] && (int'(block_y) + r < H) && (int'(block_x) + c < W)) begin
                    field_lock_d[IW'((int'(block_y) + r) * W + int'(block_x) + c)] = 1'b1;
                end
            end
        end
    end

    // Flag every row that is completely filled.
    always_comb begin
        row_full_vec = '0;
        for (int y = 0; y < H; y++) begin
            row_full_vec[y] = &field_q[y*W +: W];
        end
    end

    // Drop every row at or above row_idx by one; the top row becomes empty.
    always_comb begin
        field_shift_d = field_q;
        for (int y = 0; y < H; y++) begin
            if (y > int'(row_idx_q)) begin
                field_shift_d[y*W +: W] = field_q[y*W +: W];
            end else if (y == 0) begin
                field_shift_d[0 +: W] = '0;
            end else begin
                field_shift_d[y*W +: W] = field_q[(y-1)*W +: W];
            end
        end
    end

    assign row_full      = row_full_vec[row_idx_q];
    // The row that slides into row_idx during SHIFT is rechecked here, in the
    // same cycle, so each cleared row costs exactly one extra cycle.
    assign refill_full   = (row_idx_q != '0) && row_full_vec[row_idx_q - RW'(1)];
    assign top_rows_busy = |field_q[0 +: 2*W];

    // Lock / scan / shift / spawn sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the playfield is reset as well, since an empty board is the visible reset state.
            state_q     <= S_IDLE;
            field_q     <= '0;
            row_idx_q   <= RW'(H - 1);
            fall_step_q <= 1'b0;
            spawn_q     <= 1'b0;
            busy_q      <= 1'b0;
            lines_q     <= '0;
            over_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            fall_step_q <= 1'b0;
            spawn_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (drop_tick) begin
                        if (bottom_touch) begin
                            state_q <= S_LOCK;
                            busy_q  <= 1'b1;
                        end else begin
                            fall_step_q <= 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    field_q   <= field_lock_d;
                    lines_q   <= '0;
                    row_idx_q <= RW'(H - 1);
                    state_q   <= S_SCAN;
                end
                S_SCAN: begin
                    if (row_full) begin
                        state_q <= S_SHIFT;
                    end else if (row_idx_q == '0) begin
                        state_q <= S_SPAWN;
                        spawn_q <= 1'b1;
                    end else begin
                        row_idx_q <= row_idx_q - RW'(1);
                    end
                end
                S_SHIFT: begin
                    field_q <= field_shift_d;
                    lines_q <= lines_q + 3'd1;
                    if (refill_full) begin
                        state_q <= S_SHIFT;
                    end else if (row_idx_q == '0) begin
                        state_q <= S_SPAWN;
                        spawn_q <= 1'b1;
                    end else begin
                        row_idx_q <= row_idx_q - RW'(1);
                        state_q   <= S_SCAN;
                    end
                end
                S_SPAWN: begin
                    busy_q <= 1'b0;
                    if (top_rows_busy) begin
                        state_q <= S_OVER;
                        over_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign field     = field_q;
    assign fall_step = fall_step_q;
    assign spawn_req = spawn_q;
    assign busy      = busy_q;
    assign lines     = lines_q;
    assign game_over = over_q;

`ifdef LOCK_SCORE_EN
    logic [7:0] score_q;
    logic [8:0] score_sum;

    assign score_sum = {1'b0, score_q} + {6'd0, lines_q};

    // Add this lock's cleared rows once per spawn, saturating at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if (state_q == S_SPAWN) begin
            score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

endmodule

// File: tb/tb_lock_clear_ctrl.sv
// Testbench for lock_clear_ctrl: a reference model computes the expected board,
// line count and spawn cycle for each lock; results are queued at stimulus time
// and compared when the DUT raises spawn_req.
module tb_lock_clear_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        drop_tick;
    logic        bottom_touch;
    logic [0:8]  block;
    logic [3:0]  block_x;
    logic [3:0]  block_y;
    logic [0:99] field;
    logic        fall_step;
    logic        spawn_req;
    logic        busy;
    logic [2:0]  lines;
    logic        game_over;
    logic [7:0]  score;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [0:99] field;
        int          lines;
        int          cyc;
        bit          over;
    } exp_t;

    exp_t        sb[$];
    logic [0:99] m_field;
    int          m_score;

    lock_clear_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .drop_tick    (drop_tick),
        .bottom_touch (bottom_touch),
        .block        (block),
        .block_x      (block_x),
        .block_y      (block_y),
        .field        (field),
        .fall_step    (fall_step),
        .spawn_req    (spawn_req),
        .busy         (busy),
        .lines        (lines),
        .game_over    (game_over),
        .score        (score)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:99] merge_piece(input logic [0:99] f, input logic [0:8] blk,
                                                input int x, input int y);
        for (int i = 0; i < 9; i++) begin
            int r;
            int c;
            r = i / 3;
            c = i % 3;
            if (blk[i] && (y + r < 10) && (x + c < 10)) f[(y + r) * 10 + x + c] = 1'b1;
        end
        return f;
    endfunction

    // Compact the board: copy surviving rows from the bottom up, count dropped ones.
    function automatic logic [0:99] clear_rows(input logic [0:99] f, output int n);
        logic [0:99] g;
        int          dst;
        g   = '0;
        dst = 9;
        n   = 0;
        for (int src = 9; src >= 0; src--) begin
            if (&f[src*10 +: 10]) begin
                n++;
            end else begin
                g[dst*10 +: 10] = f[src*10 +: 10];
                dst--;
            end
        end
        return g;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_field"}, field, '0);
        check({tag, "_fall"}, fall_step, 0);
        check({tag, "_spawn"}, spawn_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_lines"}, lines, 0);
        check({tag, "_over"}, game_over, 0);
        check({tag, "_score"}, score, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        drop_tick = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        reset   = 1'b0;
        m_field = '0;
        m_score = 0;
        sb.delete();
    endtask

    task automatic do_lock(input logic [0:8] blk, input int x, input int y);
        exp_t        e;
        logic [0:99] merged;
        int          n;
        int          cyc;
        bit          seen;
        merged  = merge_piece(m_field, blk, x, y);
        e.field = clear_rows(merged, n);
        e.lines = n;
        e.cyc   = 12 + n;
        e.over  = |e.field[0:19];
        sb.push_back(e);

        @(negedge clk);
        block        = blk;
        block_x      = 4'(x);
        block_y      = 4'(y);
        bottom_touch = 1'b1;
        drop_tick    = 1'b1;
        @(posedge clk);
        #1;
        drop_tick = 1'b0;
        check("busy_in_lock", busy, 1);
        cyc  = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (spawn_req) seen = 1;
        end
        check("spawn_seen", seen, 1);
        if (seen) begin
            e = sb.pop_front();
            check("field", field, e.field);
            check("lines", lines, e.lines);
            check("spawn_cycle", cyc, e.cyc);
            check("busy_in_spawn", busy, 1);
            m_field = e.field;
`ifdef LOCK_SCORE_EN
            m_score = (m_score + e.lines > 255) ? 255 : m_score + e.lines;
`endif
            @(posedge clk);
            #1;
            check("spawn_pulse_width", spawn_req, 0);
            check("game_over", game_over, e.over);
            check("busy_after", busy, 0);
            check("score", score, m_score);
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        int activity;
        reset        = 1'b1;
        drop_tick    = 1'b0;
        bottom_touch = 1'b0;
        block        = '0;
        block_x      = '0;
        block_y      = '0;
        m_field      = '0;
        m_score      = 0;
        repeat (2) @(posedge clk);
        apply_reset();

        // Plain gravity step: one-cycle fall_step, board untouched.
        @(negedge clk);
        bottom_touch = 1'b0;
        drop_tick    = 1'b1;
        @(posedge clk);
        #1;
        drop_tick = 1'b0;
        check("fall_step_on", fall_step, 1);
        check("fall_busy", busy, 0);
        @(posedge clk);
        #1;
        check("fall_step_off", fall_step, 0);
        check("fall_field", field, '0);
        check("fall_busy2", busy, 0);

        // Horizontal piece on the bottom row, then a full 3x3 clipped at the corner.
        do_lock(9'b111_000_000, 2, 9);
        check("bits_92_94", field[92:94], 3'b111);
        do_lock(9'b111_111_111, 8, 8);
        check("corner_clip", {field[88:89], field[98:99], field[0:9]}, 14'b1111_0000000000);

        // One-row clear with a marker cell dropping from row 8 into row 9.
        apply_reset();
        do_lock(9'b111_000_000, 0, 9);
        do_lock(9'b111_000_000, 3, 9);
        do_lock(9'b100_000_000, 6, 9);
        do_lock(9'b100_000_000, 5, 8);
        do_lock(9'b111_000_000, 7, 9);
        check("bit95_moved", field[95], 1);

        // Two-row clear leaves an empty board.
        apply_reset();
        do_lock(9'b111_111_000, 0, 8);
        do_lock(9'b111_111_000, 3, 8);
        do_lock(9'b111_111_000, 6, 8);
        do_lock(9'b001_001_000, 7, 8);
        check("two_clear_empty", field, '0);

        // Lock into row 1 ends the game; later ticks change nothing.
        apply_reset();
        do_lock(9'b100_000_000, 0, 1);
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            block        = 9'b111_111_111;
            block_x      = 4'd0;
            block_y      = 4'd0;
            drop_tick    = (i < 4);
            bottom_touch = (i < 2);
            @(posedge clk);
            #1;
            if (spawn_req || fall_step || busy) activity++;
        end
        check("over_activity", activity, 0);
        check("over_field_frozen", field, m_field);
        check("over_sticky", game_over, 1);
        apply_reset();

        // Reset asserted while SHIFT is in progress aborts the clear.
        do_lock(9'b111_000_000, 0, 9);
        do_lock(9'b111_000_000, 3, 9);
        do_lock(9'b111_000_000, 6, 9);
        @(negedge clk);
        block        = 9'b100_000_000;
        block_x      = 4'd9;
        block_y      = 4'd9;
        bottom_touch = 1'b1;
        drop_tick    = 1'b1;
        @(posedge clk);
        #1;
        drop_tick = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("shift_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_shift");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_shift_edge");
        @(negedge clk);
        reset   = 1'b0;
        m_field = '0;
        m_score = 0;
        @(posedge clk);
        #1;
        check("post_abort_idle", busy, 0);

`ifdef LOCK_SCORE_EN
        // Drive the score past 255 with repeated two-row clears.
        for (int k = 0; k < 128; k++) begin
            do_lock(9'b111_111_000, 0, 8);
            do_lock(9'b111_111_000, 3, 8);
            do_lock(9'b111_111_000, 6, 8);
            do_lock(9'b001_001_000, 7, 8);
        end
        check("score_saturated", score, 255);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
